// File: rtl/mmcm_drp_pkg.sv
// mmcm_drp_pkg: shared types and constants for the MMCM DRP sequencer.
//   drp_entry_t   : one DRP register read-modify-write entry {addr, mask, data}.
//                   Mask bits set to 1 keep the value already in the register.
//   PROFILE_TABLE : DRP entries per clock profile, 100 MHz input, VCO 1000 MHz.
//                   Profile 0 = 50 MHz (CLKOUT0 /20), profile 1 = 25 MHz (/40).
//   state_t       : sequencer states. VRD_* exist only with MMCM_DRP_READBACK_EN.
package mmcm_drp_pkg;

  typedef struct packed {
    logic [6:0]  addr;
    logic [15:0] mask;
    logic [15:0] data;
  } drp_entry_t;

  localparam logic [6:0] CLKOUT0_REG1  = 7'h08;
  localparam logic [6:0] CLKOUT0_REG2  = 7'h09;
  localparam logic [6:0] CLKFBOUT_REG1 = 7'h14;
  localparam logic [6:0] DIVCLK_REG    = 7'h16;

  localparam int TABLE_PROFILES = 2;
  localparam int TABLE_REGS     = 4;

  // CLKOUT0_REG1: high time [11:6], low time [5:0]; bit 12 is reserved and kept.
  // CLKFBOUT mult 10 (5/5), DIVCLK 1 (no_count), identical for both profiles.
  localparam drp_entry_t PROFILE_TABLE [TABLE_PROFILES][TABLE_REGS] = '{
    '{ '{CLKOUT0_REG1,  16'h1000, 16'h028A},
       '{CLKOUT0_REG2,  16'hFC00, 16'h0000},
       '{CLKFBOUT_REG1, 16'h1000, 16'h0145},
       '{DIVCLK_REG,    16'hC000, 16'h1000} },
    '{ '{CLKOUT0_REG1,  16'h1000, 16'h0514},
       '{CLKOUT0_REG2,  16'hFC00, 16'h0000},
       '{CLKFBOUT_REG1, 16'h1000, 16'h0145},
       '{DIVCLK_REG,    16'hC000, 16'h1000} }
  };

  // Profiles beyond the table fall back to the power-on configuration.
  function automatic drp_entry_t profile_entry(input int prof, input int idx);
    drp_entry_t e;
    e = PROFILE_TABLE[0][0];
    for (int p = 0; p < TABLE_PROFILES; p++) begin
      for (int r = 0; r < TABLE_REGS; r++) begin
        if ((prof == p || (prof >= TABLE_PROFILES && p == 0)) && idx == r) begin
          e = PROFILE_TABLE[p][r];
        end
      end
    end
    return e;
  endfunction

  typedef enum logic [3:0] {
    S_IDLE,
    S_RST_ASSERT,
    S_RD_REQ,
    S_RD_WAIT,
    S_WR_REQ,
    S_WR_WAIT,
    S_NEXT,
    S_RST_RELEASE,
    S_WAIT_LOCK,
    S_FINISH
`ifdef MMCM_DRP_READBACK_EN
    ,
    S_VRD_REQ,
    S_VRD_WAIT
`endif
  } state_t;

endpackage

// File: rtl/mmcm_drp_sequencer_lock_watch.sv
// mmcm_lock_watch: MMCM lock synchroniser, debounce and lock timeout counter.
//   clk, rst_n    : input clock, asynchronous active-low reset.
//   locked_async  : raw MMCM locked signal (other clock domain).
//   clear         : restart the timeout counter.
//   enable        : count while waiting for lock.
//   lock_sync     : 2-flop synchronised lock.
//   lock_stable   : synchronised lock high on two consecutive cycles.
//   timeout       : counter reached LOCK_TIMEOUT (held until cleared).
module mmcm_lock_watch #(
  parameter int LOCK_TIMEOUT = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic locked_async,
  input  logic clear,
  input  logic enable,
  output logic lock_sync,
  output logic lock_stable,
  output logic timeout
);

  localparam int CW = $clog2(LOCK_TIMEOUT + 1);

  logic          meta;
  logic          sync;
  logic          sync_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      sync_d <= 1'b0;
    end else begin
      meta   <= locked_async;
      sync   <= meta;
      sync_d <= sync;
    end
  end

  // Saturates at LOCK_TIMEOUT so the timeout stays asserted until cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && cnt != CW'(LOCK_TIMEOUT)) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign lock_sync   = sync;
  assign lock_stable = sync & sync_d;
  assign timeout     = (cnt == CW'(LOCK_TIMEOUT));

endmodule

// File: rtl/mmcm_drp_sequencer.sv
// mmcm_drp_sequencer: runtime reconfiguration of the system-clock MMCM via DRP.
// Holds the MMCM in reset, read-modify-writes every DRP entry of the selected
// profile, releases reset and waits for lock. Runs on the 100 MHz input clock.
// Ports:
//   clk_i, rst_ni          : input/DRP clock, asynchronous active-low reset.
//   cfg_req_i/profile_i    : reconfiguration request (sampled in IDLE only).
//   cfg_busy_o/done_o/err_o: status; done is a 1-cycle pulse, err is sticky.
//   cur_profile_o          : profile currently active.
//   clk_valid_o            : system clock usable (drives system reset release).
//   drp_*                  : DRP master interface, one transaction at a time.
//   mmcm_rst_o/locked_i    : MMCM reset (active-high) and raw lock.
// Optional build macro MMCM_DRP_READBACK_EN: verify each write with a readback.
module mmcm_drp_sequencer
  import mmcm_drp_pkg::*;
#(
  parameter int NUM_PROFILES     = 2,
  parameter int REGS_PER_PROFILE = 4,
  parameter int LOCK_TIMEOUT     = 100000,
  parameter int DRP_TIMEOUT      = 64,
  localparam int PW = (NUM_PROFILES > 1) ? $clog2(NUM_PROFILES) : 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          cfg_req_i,
  input  logic [PW-1:0] cfg_profile_i,
  output logic          cfg_busy_o,
  output logic          cfg_done_o,
  output logic          cfg_err_o,
  output logic [PW-1:0] cur_profile_o,
  output logic          clk_valid_o,
  output logic [6:0]    drp_addr_o,
  output logic [15:0]   drp_di_o,
  input  logic [15:0]   drp_do_i,
  output logic          drp_den_o,
  output logic          drp_dwe_o,
  input  logic          drp_drdy_i,
  output logic          mmcm_rst_o,
  input  logic          mmcm_locked_i
);

  localparam int IW = (REGS_PER_PROFILE > 1) ? $clog2(REGS_PER_PROFILE) : 1;
  localparam int DW = $clog2(DRP_TIMEOUT + 1);

  state_t        state;
  state_t        next_state;
  logic [IW-1:0] idx;
  logic [PW-1:0] prof;
  logic [PW-1:0] cur_profile;
  logic [DW-1:0] drp_cnt;
  logic          err;
  logic          done;
  logic          clk_valid;
  logic          mmcm_rst;
  logic [6:0]    drp_addr;
  logic [15:0]   drp_di;
  logic          lock_sync;
  logic          lock_stable;
  logic          lock_timeout;
  logic          req_invalid;
  logic          req_same;
  logic          drp_expired;
  logic          last_entry;
  drp_entry_t    entry;
  drp_entry_t    entry_next;

  assign entry       = profile_entry(int'(prof), int'(idx));
  assign entry_next  = profile_entry(int'(prof), int'(idx) + 1);
  assign req_invalid = (int'(cfg_profile_i) >= NUM_PROFILES);
  assign req_same    = (cfg_profile_i == cur_profile);
  assign drp_expired = (drp_cnt == DW'(DRP_TIMEOUT - 1));
  assign last_entry  = (idx == IW'(REGS_PER_PROFILE - 1));

  mmcm_lock_watch #(
    .LOCK_TIMEOUT(LOCK_TIMEOUT)
  ) u_lock_watch (
    .clk         (clk_i),
    .rst_n       (rst_ni),
    .locked_async(mmcm_locked_i),
    .clear       (state == S_RST_RELEASE),
    .enable      (state == S_WAIT_LOCK),
    .lock_sync   (lock_sync),
    .lock_stable (lock_stable),
    .timeout     (lock_timeout)
  );

  // After reset the sequencer waits for the bitstream configuration to lock.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= S_WAIT_LOCK;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    cfg_busy_o = (state != S_IDLE);
    drp_den_o  = 1'b0;
    drp_dwe_o  = 1'b0;
    case (state)
      S_IDLE: begin
        if (cfg_req_i && !req_invalid && !req_same) next_state = S_RST_ASSERT;
      end
      S_RST_ASSERT: next_state = S_RD_REQ;
      S_RD_REQ: begin
        drp_den_o  = 1'b1;
        next_state = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (drp_drdy_i)       next_state = S_WR_REQ;
        else if (drp_expired) next_state = S_RST_RELEASE;
      end
      S_WR_REQ: begin
        drp_den_o  = 1'b1;
        drp_dwe_o  = 1'b1;
        next_state = S_WR_WAIT;
      end
      S_WR_WAIT: begin
`ifdef MMCM_DRP_READBACK_EN
        if (drp_drdy_i)       next_state = S_VRD_REQ;
`else
        if (drp_drdy_i)       next_state = S_NEXT;
`endif
        else if (drp_expired) next_state = S_RST_RELEASE;
      end
`ifdef MMCM_DRP_READBACK_EN
      S_VRD_REQ: begin
        drp_den_o  = 1'b1;
        next_state = S_VRD_WAIT;
      end
      S_VRD_WAIT: begin
        if (drp_drdy_i)       next_state = (drp_do_i != drp_di) ? S_RST_RELEASE : S_NEXT;
        else if (drp_expired) next_state = S_RST_RELEASE;
      end
`endif
      S_NEXT:        next_state = last_entry ? S_RST_RELEASE : S_RD_REQ;
      S_RST_RELEASE: next_state = S_WAIT_LOCK;
      S_WAIT_LOCK: begin
        if (lock_stable || lock_timeout) next_state = S_FINISH;
      end
      S_FINISH: next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx         <= '0;
      prof        <= '0;
      cur_profile <= '0;
      drp_cnt     <= '0;
      err         <= 1'b0;
      done        <= 1'b0;
      clk_valid   <= 1'b0;
      mmcm_rst    <= 1'b0;
      drp_addr    <= '0;
      drp_di      <= '0;
    end else begin
      done <= (next_state == S_FINISH);
      if (next_state == S_RST_RELEASE) mmcm_rst <= 1'b0;
      case (state)
        S_IDLE: begin
          // Lock loss in IDLE only drops clk_valid; no automatic retry.
          if (!lock_sync) clk_valid <= 1'b0;
          if (cfg_req_i) begin
            if (req_invalid) begin
              err  <= 1'b1;
              done <= 1'b1;
            end else if (req_same) begin
              err  <= 1'b0;
              done <= 1'b1;
            end else begin
              err       <= 1'b0;
              prof      <= cfg_profile_i;
              idx       <= '0;
              mmcm_rst  <= 1'b1;
              clk_valid <= 1'b0;
            end
          end
        end
        S_RST_ASSERT: drp_addr <= entry.addr;
        S_RD_REQ, S_WR_REQ: drp_cnt <= '0;
        S_RD_WAIT: begin
          drp_cnt <= drp_cnt + DW'(1);
          if (drp_drdy_i)       drp_di <= (drp_do_i & entry.mask) | (entry.data & ~entry.mask);
          else if (drp_expired) err <= 1'b1;
        end
        S_WR_WAIT: begin
          drp_cnt <= drp_cnt + DW'(1);
          if (!drp_drdy_i && drp_expired) err <= 1'b1;
        end
`ifdef MMCM_DRP_READBACK_EN
        S_VRD_REQ: drp_cnt <= '0;
        S_VRD_WAIT: begin
          drp_cnt <= drp_cnt + DW'(1);
          if (drp_drdy_i) begin
            if (drp_do_i != drp_di) err <= 1'b1;
          end else if (drp_expired) begin
            err <= 1'b1;
          end
        end
`endif
        S_NEXT: begin
          if (!last_entry) begin
            idx      <= idx + IW'(1);
            drp_addr <= entry_next.addr;
          end
        end
        S_WAIT_LOCK: begin
          // An aborted sequence still reports a usable clock but keeps the
          // previous profile number, since the register set is incomplete.
          if (lock_stable) begin
            clk_valid <= 1'b1;
            if (!err) cur_profile <= prof;
          end else if (lock_timeout) begin
            err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign cfg_done_o    = done;
  assign cfg_err_o     = err;
  assign cur_profile_o = cur_profile;
  assign clk_valid_o   = clk_valid;
  assign drp_addr_o    = drp_addr;
  assign drp_di_o      = drp_di;
  assign mmcm_rst_o    = mmcm_rst;

endmodule

// File: tb/tb_mmcm_drp_sequencer.sv
// Testbench for mmcm_drp_sequencer: DRP slave + MMCM lock model, table-driven
// reconfiguration vectors and hand-written multi-cycle corner sequences.
// Built with NUM_PROFILES=3 so that an out-of-range profile (3) is encodable,
// and with a short LOCK_TIMEOUT to keep the lock-timeout case quick.
module tb_mmcm_drp_sequencer;

`ifdef MMCM_DRP_READBACK_EN
  localparam int RB = 1;
`else
  localparam int RB = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_req = 1'b0;
  logic [1:0]  cfg_profile = '0;
  logic        cfg_busy, cfg_done, cfg_err, clk_valid;
  logic [1:0]  cur_profile;
  logic [6:0]  drp_addr;
  logic [15:0] drp_di;
  logic [15:0] drp_do = '0;
  logic        drp_den, drp_dwe;
  logic        drp_drdy = 1'b0;
  logic        mmcm_rst;
  logic        mmcm_locked = 1'b0;

  always #5 clk = ~clk;

  mmcm_drp_sequencer #(
    .NUM_PROFILES(3), .REGS_PER_PROFILE(4), .LOCK_TIMEOUT(300), .DRP_TIMEOUT(64)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .cfg_req_i(cfg_req), .cfg_profile_i(cfg_profile),
    .cfg_busy_o(cfg_busy), .cfg_done_o(cfg_done), .cfg_err_o(cfg_err),
    .cur_profile_o(cur_profile), .clk_valid_o(clk_valid),
    .drp_addr_o(drp_addr), .drp_di_o(drp_di), .drp_do_i(drp_do),
    .drp_den_o(drp_den), .drp_dwe_o(drp_dwe), .drp_drdy_i(drp_drdy),
    .mmcm_rst_o(mmcm_rst), .mmcm_locked_i(mmcm_locked)
  );

  // Model controls (driven from the test process)
  int   ack_delay = 3;
  logic no_ack = 1'b0;
  logic corrupt = 1'b0;
  logic lock_en = 1'b0;

  // Model state and monotonic event counters
  logic [15:0] mem [128];
  logic        mem_loaded = 1'b0;
  logic        pend = 1'b0;
  int          wait_cnt = 0;
  logic [15:0] rd_val = '0;
  logic        last_wr = 1'b0;
  int          nrd = 0, nwr = 0, ndone = 0, viol = 0, lcnt = 0;

  always @(posedge clk) begin
    logic [15:0] v;
    drp_drdy <= 1'b0;
    if (!rst_n) begin
      pend <= 1'b0;
      if (!mem_loaded) begin
        for (int i = 0; i < 128; i++) mem[i] <= 16'h0000;
        mem[8'h08] <= 16'hF28A;
        mem_loaded <= 1'b1;
      end
    end else if (pend) begin
      if (wait_cnt == 0) begin
        drp_drdy <= 1'b1;
        drp_do   <= rd_val;
        pend     <= 1'b0;
      end else begin
        wait_cnt <= wait_cnt - 1;
      end
    end
    if (rst_n && drp_den) begin
      if (!mmcm_rst) viol <= viol + 1;
      if (drp_dwe) begin
        mem[drp_addr] <= drp_di;
        nwr     <= nwr + 1;
        last_wr <= 1'b1;
      end else begin
        v = mem[drp_addr];
        if (corrupt && last_wr) v = v ^ 16'h0001;
        rd_val  <= v;
        nrd     <= nrd + 1;
        last_wr <= 1'b0;
      end
      if (!no_ack) begin
        pend     <= 1'b1;
        wait_cnt <= ack_delay;
      end
    end
    if (cfg_done) ndone <= ndone + 1;
  end

  // MMCM model: locks 5 cycles after reset release when enabled.
  always @(posedge clk) begin
    if (mmcm_rst || !lock_en) begin
      mmcm_locked <= 1'b0;
      lcnt        <= 0;
    end else if (lcnt < 5) begin
      lcnt <= lcnt + 1;
    end else begin
      mmcm_locked <= 1'b1;
    end
  end

  int nchk = 0, nerr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  int rd_d, wr_d;

  task automatic run_req(input logic [1:0] prof);
    int n, rd0, wr0, dn0;
    n = 0;
    while (cfg_busy && n < 3000) begin @(negedge clk); n++; end
    check("idle_before_req", {31'd0, cfg_busy}, 0);
    rd0 = nrd; wr0 = nwr; dn0 = ndone;
    cfg_req = 1'b1; cfg_profile = prof;
    @(negedge clk);
    cfg_req = 1'b0;
    n = 0;
    while (ndone == dn0 && n < 3000) begin @(negedge clk); n++; end
    check("done_seen", 32'(ndone != dn0), 1);
    @(negedge clk); @(negedge clk);
    check("single_done_pulse", 32'(ndone - dn0), 1);
    rd_d = nrd - rd0;
    wr_d = nwr - wr0;
  endtask

  typedef struct {
    logic [1:0]  prof;
    int          delay;
    logic        na;
    logic        exp_err;
    logic [1:0]  exp_cur;
    int          exp_rd;
    int          exp_wr;
    logic        exp_valid;
    logic        chk_reg8;
    logic [15:0] exp_reg8;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int n;
    vecs[0] = '{2'd1, 3, 1'b0, 1'b0, 2'd1, 4*(1+RB), 4, 1'b1, 1'b1, 16'h1514};
    vecs[1] = '{2'd1, 3, 1'b0, 1'b0, 2'd1, 0,        0, 1'b1, 1'b0, 16'h0000};
    vecs[2] = '{2'd3, 3, 1'b0, 1'b1, 2'd1, 0,        0, 1'b1, 1'b0, 16'h0000};
    vecs[3] = '{2'd0, 1, 1'b0, 1'b0, 2'd0, 4*(1+RB), 4, 1'b1, 1'b1, 16'h128A};
    vecs[4] = '{2'd1, 3, 1'b1, 1'b1, 2'd0, 1,        0, 1'b1, 1'b0, 16'h0000};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, cfg_busy}, 1);
    check("rst_done", {31'd0, cfg_done}, 0);
    check("rst_err", {31'd0, cfg_err}, 0);
    check("rst_valid", {31'd0, clk_valid}, 0);
    check("rst_mmcm_rst", {31'd0, mmcm_rst}, 0);
    check("rst_drp", {7'd0, drp_den, drp_dwe, drp_addr, drp_di}, 0);
    rst_n = 1'b1;

    // Power-on lock: no valid clock before lock, then valid with profile 0
    repeat (9) @(negedge clk);
    check("pwr_valid_before_lock", {31'd0, clk_valid}, 0);
    lock_en = 1'b1;
    n = 0;
    while (!clk_valid && n < 20) begin @(negedge clk); n++; end
    check("pwr_valid", {31'd0, clk_valid}, 1);
    check("pwr_profile", {30'd0, cur_profile}, 0);
    check("pwr_no_drp", 32'(nrd + nwr), 0);

    // Table-driven reconfiguration requests
    for (int i = 0; i < 5; i++) begin
      ack_delay = vecs[i].delay;
      no_ack    = vecs[i].na;
      run_req(vecs[i].prof);
      check($sformatf("v%0d_err", i), {31'd0, cfg_err}, {31'd0, vecs[i].exp_err});
      check($sformatf("v%0d_cur", i), {30'd0, cur_profile}, {30'd0, vecs[i].exp_cur});
      check($sformatf("v%0d_rd", i), rd_d, vecs[i].exp_rd);
      check($sformatf("v%0d_wr", i), wr_d, vecs[i].exp_wr);
      check($sformatf("v%0d_valid", i), {31'd0, clk_valid}, {31'd0, vecs[i].exp_valid});
      check($sformatf("v%0d_mmcm_rst", i), {31'd0, mmcm_rst}, 0);
      if (vecs[i].chk_reg8) check($sformatf("v%0d_reg08", i), {16'd0, mem[8'h08]}, {16'd0, vecs[i].exp_reg8});
    end
    no_ack = 1'b0;
    check("den_only_in_reset", viol, 0);

    // Lock loss in IDLE drops clk_valid within 3 cycles of the lock edge
    @(negedge clk);
    lock_en = 1'b0;
    n = 0;
    while (clk_valid && n < 10) begin @(negedge clk); n++; end
    check("lockloss_latency_ok", 32'(n <= 4), 1);
    check("lockloss_valid", {31'd0, clk_valid}, 0);

    // Lock never returns: lock timeout error, clk_valid stays low
    run_req(2'd1);
    check("lto_err", {31'd0, cfg_err}, 1);
    check("lto_valid", {31'd0, clk_valid}, 0);
    check("lto_cur", {30'd0, cur_profile}, 0);
    check("lto_mmcm_rst", {31'd0, mmcm_rst}, 0);
    lock_en = 1'b1;

    // Asynchronous reset while waiting for a read ack
    no_ack = 1'b1;
    n = nrd;
    cfg_req = 1'b1; cfg_profile = 2'd1;
    @(negedge clk);
    cfg_req = 1'b0;
    begin
      int k;
      k = 0;
      while (nrd == n && k < 20) begin @(negedge clk); k++; end
    end
    repeat (3) @(negedge clk);
    check("mid_mmcm_rst_high", {31'd0, mmcm_rst}, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, cfg_busy}, 1);
    check("arst_err", {31'd0, cfg_err}, 0);
    check("arst_cur_valid", {29'd0, cur_profile, clk_valid}, 0);
    check("arst_mmcm_rst", {31'd0, mmcm_rst}, 0);
    check("arst_drp", {7'd0, drp_den, drp_dwe, drp_addr, drp_di}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    no_ack = 1'b0;
    n = 0;
    while (cfg_busy && n < 100) begin @(negedge clk); n++; end
    check("arst_relock_valid", {31'd0, clk_valid}, 1);

`ifdef MMCM_DRP_READBACK_EN
    // Readback corruption aborts after the first entry
    corrupt = 1'b1;
    ack_delay = 2;
    run_req(2'd1);
    check("rb_err", {31'd0, cfg_err}, 1);
    check("rb_rd", rd_d, 2);
    check("rb_wr", wr_d, 1);
    check("rb_cur", {30'd0, cur_profile}, 0);
    corrupt = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
